// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types and constants for the fifo_drain_ctrl slice.
//   drain_state_t : read-controller FSM states
//   BUF_DEPTH     : entries in the output skid buffer
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } drain_state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// fifo_drain_ctrl_if: bundles the fifo_mem read side and the downstream
// valid/ready stream.
//   fifo_read / fifo_data / fifo_empty / fifo_threshold : fifo_mem read port
//   m_valid / m_ready / m_data                          : output stream
// modport master : the drain controller
// modport slave  : the environment (fifo_mem plus stream sink)
interface fifo_drain_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_read;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_threshold;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output fifo_read, m_valid, m_data,
    input  fifo_data, fifo_empty, fifo_threshold, m_ready
  );

  modport slave (
    input  fifo_read, m_valid, m_data,
    output fifo_data, fifo_empty, fifo_threshold, m_ready
  );
endinterface

// File: rtl/fifo_drain_ctrl_stream_buf2.sv
// stream_buf2: 2-entry in-order valid/ready buffer.
//   clk_in, areset_b : clock, asynchronous active-low reset
//   push, data_in    : write one word (caller guarantees space)
//   occ              : current occupancy 0..2
//   m_valid, m_ready, m_data : output stream, head entry presented
module stream_buf2
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [1:0]            occ,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [1:0]            occ_q;
  logic                  pop;

  assign pop     = (occ_q != 2'd0) && m_ready;
  assign occ     = occ_q;
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head;

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      head  <= '0;
      tail  <= '0;
      occ_q <= 2'd0;
    end else if (pop && push) begin
      // Occupancy unchanged; the new word lands behind whatever stays.
      if (occ_q == 2'd1) begin
        head <= data_in;
      end else begin
        head <= tail;
        tail <= data_in;
      end
    end else if (pop) begin
      head  <= tail;
      occ_q <= occ_q - 2'd1;
    end else if (push && (occ_q != 2'(BUF_DEPTH))) begin
      if (occ_q == 2'd0) head <= data_in;
      else               tail <= data_in;
      occ_q <= occ_q + 2'd1;
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side controller for fifo_mem. Issues bursts of
// single-cycle reads when the FIFO crosses its threshold or has held data
// for TIMEOUT cycles, and re-times the 1-cycle-latency FIFO data into a
// valid/ready stream through a 2-entry buffer.
//   clk_in, areset_b : clock, asynchronous active-low reset
//   bus (master)     : fifo_mem read port + output stream
//   burst_active     : registered, high while in BURST
//   burst_cnt        : reads issued in the current burst (saturating)
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int BURST_LEN  = 8,
  parameter  int TIMEOUT    = 16,
  localparam int CNT_W      = $clog2(BURST_LEN + 1)
) (
  input  logic               clk_in,
  input  logic               areset_b,
  fifo_drain_ctrl_if.master  bus,
  output logic               burst_active,
  output logic [CNT_W-1:0]   burst_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  drain_state_t     state, next_state;
  logic [TMR_W-1:0] timer, timer_next;
  logic [CNT_W-1:0] cnt_next;
  logic             inflight;
  logic [1:0]       occ;
  logic             pop;
  logic [2:0]       pending;
  logic             credit_ok;
  logic             rd;

  // A read now lands in the buffer two edges later, so words already read
  // (buffered + in flight) must leave room, counting a same-cycle pop.
  assign pop       = bus.m_valid && bus.m_ready;
  assign pending   = {1'b0, occ} + {2'b00, inflight};
  assign credit_ok = pending < (3'd2 + {2'b00, pop});
  assign rd        = (state == BURST) && !bus.fifo_empty && credit_ok;
  assign bus.fifo_read = rd;

  always_comb begin
    next_state = state;
    timer_next = timer;
    cnt_next   = burst_cnt;
    case (state)
      IDLE: begin
        if (bus.fifo_threshold) begin
          next_state = BURST;
          cnt_next   = '0;
        end else if (!bus.fifo_empty) begin
          next_state = WAIT;
          timer_next = '0;
        end
      end
      WAIT: begin
        if (timer != {TMR_W{1'b1}}) timer_next = timer + 1'b1;
        if (bus.fifo_threshold || (timer == TMR_W'(TIMEOUT - 1))) begin
          next_state = BURST;
          cnt_next   = '0;
        end else if (bus.fifo_empty) begin
          next_state = IDLE;
        end
      end
      BURST: begin
        if (rd) begin
          if (burst_cnt != CNT_W'(BURST_LEN)) cnt_next = burst_cnt + 1'b1;
          if (burst_cnt == CNT_W'(BURST_LEN - 1)) next_state = IDLE;
        end else if (bus.fifo_empty) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      state        <= IDLE;
      timer        <= '0;
      burst_cnt    <= '0;
      inflight     <= 1'b0;
      burst_active <= 1'b0;
    end else begin
      state        <= next_state;
      timer        <= timer_next;
      burst_cnt    <= cnt_next;
      inflight     <= rd;
      burst_active <= (next_state == BURST);
    end
  end

  stream_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_in   (clk_in),
    .areset_b (areset_b),
    .push     (inflight),
    .data_in  (bus.fifo_data),
    .occ      (occ),
    .m_valid  (bus.m_valid),
    .m_ready  (bus.m_ready),
    .m_data   (bus.m_data)
  );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed + randomized bench for fifo_drain_ctrl with a
// queue-based fifo_mem model (depth 18, threshold 9) and an in-order
// scoreboard of words read from the FIFO but not yet delivered.
module tb_fifo_drain_ctrl;

  localparam int DW    = 16;
  localparam int BL    = 8;
  localparam int TO    = 16;
  localparam int DEPTH = 18;
  localparam int THR   = 9;

  logic       clk = 1'b0;
  logic       areset_b;
  logic       burst_active;
  logic [3:0] burst_cnt;

  always #5 clk = ~clk;

  fifo_drain_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_drain_ctrl #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .TIMEOUT    (TO)
  ) dut (
    .clk_in       (clk),
    .areset_b     (areset_b),
    .bus          (bus),
    .burst_active (burst_active),
    .burst_cnt    (burst_cnt)
  );

  logic [DW-1:0] fq[$];   // fifo_mem contents
  logic [DW-1:0] rq[$];   // read from FIFO, not yet taken by the sink
  int total  = 0;
  int passed = 0;
  int popped = 0;
  int written = 0;
  logic s_read, s_pop, s_active, s_valid;
  logic [DW-1:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_flags();
    bus.fifo_empty     = (fq.size() == 0);
    bus.fifo_threshold = (fq.size() >= THR);
  endtask

  // One clock: sample and check at negedge, update the FIFO model after the edge.
  task automatic cycle(input bit wr_en = 1'b0, input logic [DW-1:0] wr_data = '0);
    int pend;
    @(negedge clk);
    s_read   = bus.fifo_read;
    s_active = burst_active;
    s_valid  = bus.m_valid;
    s_data   = bus.m_data;
    s_pop    = bus.m_valid && bus.m_ready;
    if (s_read) begin
      pend = rq.size() - (s_pop ? 1 : 0);
      chk("read_nonempty", {31'b0, bus.fifo_empty}, 32'd0);
      chk("read_credit", {31'b0, (pend < 2)}, 32'd1);
    end
    if (s_pop) begin
      if (rq.size() == 0) chk("pop_underrun", 32'd1, 32'd0);
      else begin
        chk("pop_data", {16'b0, bus.m_data}, {16'b0, rq[0]});
        void'(rq.pop_front());
        popped++;
      end
    end
    @(posedge clk);
    #1;
    if (s_read && fq.size() > 0) begin
      bus.fifo_data = fq.pop_front();
      rq.push_back(bus.fifo_data);
    end
    if (wr_en && fq.size() < DEPTH) begin
      fq.push_back(wr_data);
      written++;
    end
    drive_flags();
  endtask

  initial begin
    int n, reads, run, gap, rem, target;
    areset_b      = 1'b0;
    bus.m_ready   = 1'b1;
    bus.fifo_data = '0;
    for (int i = 1; i <= 10; i++) fq.push_back(DW'(i));
    drive_flags();

    // Reset hold with a non-empty, above-threshold FIFO
    repeat (3) begin
      @(negedge clk);
      chk("rst_read",   {31'b0, bus.fifo_read}, 32'd0);
      chk("rst_valid",  {31'b0, bus.m_valid}, 32'd0);
      chk("rst_data",   {16'b0, bus.m_data}, 32'd0);
      chk("rst_active", {31'b0, burst_active}, 32'd0);
      chk("rst_cnt",    {28'b0, burst_cnt}, 32'd0);
    end
    @(posedge clk);
    #1;
    areset_b = 1'b1;

    // Threshold burst: one IDLE cycle, 8 back-to-back reads
    n = 0;
    do begin cycle(); n++; end while (!s_active && n < 10);
    chk("burst1_entry", n, 2);
    reads = s_read; run = 1;
    while (s_active && run < 40) begin
      cycle();
      if (s_active) begin run++; reads += s_read; end
    end
    chk("burst1_reads", reads, BL);
    chk("burst1_len", run, BL);
    // IDLE for one cycle, then WAIT for TIMEOUT cycles
    gap = 1;
    while (!s_active && gap < 60) begin
      cycle();
      if (!s_active) gap++;
    end
    chk("wait_gap", gap, 1 + TO);
    reads = s_read; run = 1;
    while (s_active && run < 40) begin
      cycle();
      if (s_active) begin run++; reads += s_read; end
    end
    chk("burst2_reads", reads, 2);
    chk("burst2_len", run, 3);
    repeat (6) cycle();
    chk("t2_words_out", popped, 10);
    chk("t2_rq_empty", rq.size(), 0);

    // Timeout drain of a single word
    popped = 0;
    cycle(1'b1, 16'h00AB);
    n = 0;
    cycle();
    while (!s_read && n < 40) begin n++; cycle(); end
    chk("t3_wait_cycles", n, 1 + TO);
    cycle();
    chk("t3_valid_early", {31'b0, s_valid}, 32'd0);
    cycle();
    chk("t3_valid_lat", {31'b0, s_valid}, 32'd1);
    chk("t3_data", {16'b0, s_data}, 32'h00AB);
    repeat (4) cycle();
    chk("t3_count", popped, 1);

    // Backpressure: buffer fills to 2 and holds word 1
    popped = 0;
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) fq.push_back(DW'(16'h0100 + i));
    drive_flags();
    reads = 0;
    repeat (30) begin cycle(); reads += s_read; end
    chk("bp_reads", reads, 2);
    chk("bp_active", {31'b0, s_active}, 32'd1);
    repeat (3) begin
      cycle();
      chk("bp_hold_valid", {31'b0, s_valid}, 32'd1);
      chk("bp_hold_data", {16'b0, s_data}, 32'h0101);
    end
    bus.m_ready = 1'b1;
    n = 0;
    while (popped < 6 && n < 60) begin cycle(); n++; end
    chk("bp_count", popped, 6);
    repeat (4) cycle();
    chk("bp_fifo_empty", fq.size(), 0);

    // Concurrent write every cycle, sink ready every other cycle
    popped = 0; written = 0;
    for (int i = 0; i < 24; i++) begin
      bus.m_ready = i[0];
      cycle(1'b1, DW'($urandom));
    end
    target = written;
    bus.m_ready = 1'b1;
    n = 0;
    while (popped < target && n < 300) begin cycle(); n++; end
    chk("t5_count", popped, target);
    chk("t5_written", written, 24);

    // Random writes and random sink stalls
    popped = 0; written = 0;
    for (int i = 0; i < 80; i++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      cycle(($urandom_range(0, 1) == 1) && (fq.size() < 16), DW'($urandom));
    end
    target = written;
    bus.m_ready = 1'b1;
    n = 0;
    while (popped < target && n < 400) begin cycle(); n++; end
    chk("rand_count", popped, target);

    // Reset mid-burst, then resume draining in order
    repeat (4) cycle();
    rq.delete();
    popped = 0;
    for (int i = 0; i < 12; i++) fq.push_back(DW'(16'h0600 + i));
    drive_flags();
    n = 0;
    while (burst_cnt != 4'd3 && n < 40) begin cycle(); n++; end
    chk("t6_cnt3", {28'b0, burst_cnt}, 32'd3);
    areset_b = 1'b0;
    #1;
    chk("t6_rst_read",   {31'b0, bus.fifo_read}, 32'd0);
    chk("t6_rst_valid",  {31'b0, bus.m_valid}, 32'd0);
    chk("t6_rst_data",   {16'b0, bus.m_data}, 32'd0);
    chk("t6_rst_active", {31'b0, burst_active}, 32'd0);
    chk("t6_rst_cnt",    {28'b0, burst_cnt}, 32'd0);
    rq.delete();
    rem = fq.size();
    chk("t6_remaining", rem, 9);
    repeat (2) cycle();
    areset_b = 1'b1;
    popped = 0;
    n = 0;
    while (popped < rem && n < 200) begin cycle(); n++; end
    chk("t6_resume_count", popped, rem);
    chk("t6_fifo_empty", fq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
Read-side controller for fifo_mem. It watches the FIFO's empty and threshold flags and issues trans_read pulses in bursts. It converts the FIFO's registered data_out into a valid/ready stream for a downstream consumer. It sits between fifo_mem and any stream sink, so sinks never see the FIFO's read latency or underflow.

Parameters:
DATA_WIDTH, 16, width of FIFO data and stream data
BURST_LEN, 8, maximum reads per burst (>=1)
TIMEOUT, 16, cycles a non-empty, below-threshold FIFO waits before a forced drain burst (>=1)

Ports:
clk_in  input  1  single clock, all logic rising-edge
areset_b  input  1  asynchronous active-low reset
fifo_read  output  1  drives fifo_mem trans_read; one read per high cycle
fifo_data  input  DATA_WIDTH  fifo_mem data_out; valid on the cycle after a fifo_read cycle
fifo_empty  input  1  fifo_mem empty_ind
fifo_threshold  input  1  fifo_mem threshold_ind
m_valid  output  1  stream data valid
m_ready  input  1  stream sink ready
m_data  output  DATA_WIDTH  stream data
burst_active  output  1  high while the FSM is in BURST
burst_cnt  output  $clog2(BURST_LEN+1)  reads issued in the current burst

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, buffer cleared, inflight=0, timer=0.
- Reset values: fifo_read=0, m_valid=0, m_data=0, burst_active=0, burst_cnt=0.
- Reset mid-burst drops any buffered or in-flight word; the output is not required to be lossless across reset.
- FIFO read latency is fixed at 1 cycle. A read issued in cycle k is captured from fifo_data at the rising edge ending cycle k+1. The inflight register tracks this read.
- Output buffer: 2 entries (occ 0..2), in-order.
  - m_valid = (occ != 0); m_data = head entry.
  - m_valid and m_data are held stable while m_valid && !m_ready.
  - Pop on m_valid && m_ready. Push when inflight=1. Push and pop may occur in the same cycle; occ is then unchanged.
- Credit rule (combinational): fifo_read = (state==BURST) && !fifo_empty && (occ + inflight - pop < 2).
  - Never overflows the buffer; never reads an empty FIFO, so fifo_mem underflow_ind never asserts due to this block.
- Full throughput: a sustained m_ready=1 and a non-empty FIFO give one word per cycle after 2 cycles of fill latency.
- FSM states IDLE, WAIT, BURST:
  - IDLE: fifo_threshold=1 -> BURST. Else fifo_empty=0 -> WAIT with timer cleared.
  - WAIT: timer increments each cycle.
    - fifo_threshold=1 or timer==TIMEOUT-1 -> BURST.
    - fifo_empty=1 -> IDLE, which cannot normally happen since this block is the only reader.
  - BURST: burst_cnt increments on each fifo_read.
    - Leave to IDLE when burst_cnt reaches BURST_LEN (after the final read), or when fifo_empty=1 and no read is issued that cycle.
    - burst_cnt clears on entry to BURST.
    - In-flight and buffered words still drain after leaving BURST.
- burst_active = (state==BURST), registered.
- Counters saturate and never wrap. The timer is sized $clog2(TIMEOUT+1).
- A simultaneous fifo_threshold rise and timer expiry is a single transition to BURST.

Decomposition:
- Package fifo_drain_pkg holds: drain_state_t enum {IDLE, WAIT, BURST}, and the constant BUF_DEPTH=2.
- One sub-module, stream_buf2: a 2-entry in-order valid/ready buffer with push, data_in, occ output, m_valid/m_ready/m_data, async active-low reset.
- The FSM, credit logic, timer and burst counter stay in fifo_drain_ctrl.

Test Plan:
1. Reset hold: areset_b=0 for 3 cycles with FIFO non-empty -> fifo_read=0, m_valid=0, m_data=0, burst_active=0 throughout.
2. Threshold burst: pre-load fifo_mem (OSTD_NUM=18, THRESHOLD_VALUE=9) with 0x0001..0x000A, m_ready=1.
   - BURST is entered the cycle after threshold_ind.
   - Exactly 8 fifo_read cycles occur; m_data emits 0x0001..0x0008 in order.
   - Then IDLE, then WAIT; after 16 cycles, a second burst drains 0x0009..0x000A and exits on empty.
3. Timeout drain: write a single word 0x00AB -> WAIT for exactly TIMEOUT=16 cycles, then 1 read. m_data=0x00AB appears 2 cycles after fifo_read; underflow_ind stays 0.
4. Backpressure: load 6 words, m_ready=0 -> fifo_read stops after 2 reads (occ=2) and m_data is held at word 1. Release m_ready -> the remaining 4 words follow in order with no loss or duplication.
5. Concurrent write/read: write every cycle while the sink takes one word every other cycle.
   - Output sequence equals input sequence.
   - fifo_read is never high while fifo_empty=1.
   - fifo_read is never high while occ+inflight=2.
6. Reset mid-burst: assert areset_b=0 during burst_cnt=3 -> all outputs return to reset values within the same cycle. After release, the FSM restarts from IDLE and resumes draining the remaining FIFO contents in order.
